// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: writeback source codes and load size codes.
package mips_pkg;

  // Writeback mux source select codes (index of the x0..x7 candidate).
  localparam logic [2:0] WB_SRC_ALU  = 3'd0;
  localparam logic [2:0] WB_SRC_LOAD = 3'd1;
  localparam logic [2:0] WB_SRC_LINK = 3'd2;
  localparam logic [2:0] WB_SRC_LUI  = 3'd3;
  localparam logic [2:0] WB_SRC_HI   = 3'd4;
  localparam logic [2:0] WB_SRC_LO   = 3'd5;
  localparam logic [2:0] WB_SRC_SLT  = 3'd6;
  localparam logic [2:0] WB_SRC_ZERO = 3'd7;

  // Load access size codes; 2'b11 is reserved and handled as a word.
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  // Sign- or zero-extend a byte to 32 bits.
  function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
    return {{24{~uns & v[7]}}, v};
  endfunction

  // Sign- or zero-extend a halfword to 32 bits.
  function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
    return {{16{~uns & v[15]}}, v};
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load alignment and extension, plus natural-alignment check.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data32_o,
  output logic        misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/half lane (byte 0 is the MSB lane) and extend.
  always_comb begin
    byte_v     = 8'h00;
    half_v     = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    data32_o   = rdata_i;
    misalign_o = 1'b0;
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[31:24];
      2'd1:    byte_v = rdata_i[23:16];
      2'd2:    byte_v = rdata_i[15:8];
      default: byte_v = rdata_i[7:0];
    endcase
    case (size_i)
      LD_BYTE: data32_o = ext8(byte_v, uns_i);
      LD_HALF: begin
        data32_o   = ext16(half_v, uns_i);
        misalign_o = addr_lo_i[0];
      end
      default: begin
        data32_o   = rdata_i;
        misalign_o = (addr_lo_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: holds MEM results, aligned load data, HI/LO state,
// and presents the eight writeback candidates plus select to the WB mux.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rdata,
  input  logic [1:0]  in_addr_lo,
  input  logic [1:0]  in_ld_size,
  input  logic        in_ld_uns,
  input  logic [31:0] in_pc8,
  input  logic [15:0] in_imm,
  input  logic [2:0]  in_src,
  input  logic [4:0]  in_rd,
  input  logic        in_we,
  input  logic        in_hi_we,
  input  logic        in_lo_we,
  input  logic [31:0] in_hi_d,
  input  logic [31:0] in_lo_d,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] x0,
  output logic [31:0] x1,
  output logic [31:0] x2,
  output logic [31:0] x3,
  output logic [31:0] x4,
  output logic [31:0] x5,
  output logic [31:0] x6,
  output logic [31:0] x7,
  output logic [2:0]  wb_sel,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        ld_misalign
);

  logic        cap;
  logic [31:0] ld_data;
  logic        ld_mis_raw;

  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] pc8_q, pc8_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] lo_snap_q, lo_snap_d;
  logic [2:0]  src_q, src_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic        mis_q, mis_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Align before the register so the held entry already carries final load data.
  load_align u_align (
    .rdata_i    (in_rdata),
    .addr_lo_i  (in_addr_lo),
    .size_i     (in_ld_size),
    .uns_i      (in_ld_uns),
    .data32_o   (ld_data),
    .misalign_o (ld_mis_raw)
  );

  // A flush blocks acceptance, which also suppresses the incoming HI/LO writes.
  assign in_ready = (~valid_q | wb_ready) & ~flush;
  assign cap      = in_valid & in_ready;

  // Next-state: capture a new entry, drain/flush the held one, update HI/LO.
  always_comb begin
    valid_d   = valid_q;
    alu_d     = alu_q;
    ld_d      = ld_q;
    pc8_d     = pc8_q;
    imm_d     = imm_q;
    hi_snap_d = hi_snap_q;
    lo_snap_d = lo_snap_q;
    src_d     = src_q;
    rd_d      = rd_q;
    we_d      = we_q;
    mis_d     = mis_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (cap) begin
      valid_d   = 1'b1;
      alu_d     = in_alu;
      ld_d      = ld_data;
      pc8_d     = in_pc8;
      imm_d     = in_imm;
      // Snapshot is the value before this op's own HI/LO write.
      hi_snap_d = hi_q;
      lo_snap_d = lo_q;
      src_d     = in_src;
      rd_d      = in_rd;
      we_d      = in_we;
      mis_d     = ld_mis_raw & (in_src == WB_SRC_LOAD);
      if (in_hi_we) hi_d = in_hi_d;
      if (in_lo_we) lo_d = in_lo_d;
    end else if (flush | wb_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards the held entry and clears HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_q     <= 32'h0;
      ld_q      <= 32'h0;
      pc8_q     <= RESET_PC;
      imm_q     <= 16'h0;
      hi_snap_q <= 32'h0;
      lo_snap_q <= 32'h0;
      src_q     <= WB_SRC_ALU;
      rd_q      <= 5'd0;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      ld_q      <= ld_d;
      pc8_q     <= pc8_d;
      imm_q     <= imm_d;
      hi_snap_q <= hi_snap_d;
      lo_snap_q <= lo_snap_d;
      src_q     <= src_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      mis_q     <= mis_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign wb_valid    = valid_q;
  assign x0          = alu_q;
  assign x1          = ld_q;
  assign x2          = pc8_q;
  assign x3          = {imm_q, 16'h0};
  assign x4          = hi_snap_q;
  assign x5          = lo_snap_q;
  assign x6          = {31'b0, alu_q[31]};
  assign x7          = 32'h0;
  assign wb_sel      = src_q;
  assign wb_rd       = rd_q;
  assign ld_misalign = mis_q;
  // r0 is hardwired; misaligned loads never commit.
  assign wb_we       = valid_q & we_q & (rd_q != 5'd0) & ~mis_q;

endmodule
